// File: rtl/ram_bus_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_bus_driver_pkg
//  Brief    : Shared widths, FSM state encodings and helpers for the PSRAM driver.
//  Revision : 1.0 - initial release
// ============================================================================
package ram_bus_driver_pkg;

    localparam int c_RAM_ADDR_W = 23;
    localparam int c_RAM_DATA_W = 16;

    localparam int                    c_STATE_W = 3;
    localparam logic [c_STATE_W-1:0]  c_S_IDLE  = 3'd0;
    localparam logic [c_STATE_W-1:0]  c_S_ADDR  = 3'd1;
    localparam logic [c_STATE_W-1:0]  c_S_WAIT  = 3'd2;
    localparam logic [c_STATE_W-1:0]  c_S_DATA  = 3'd3;
    localparam logic [c_STATE_W-1:0]  c_S_RECOV = 3'd4;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int f_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_bus_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_bus_driver_if
//  Brief    : Request, write/read data and PSRAM pin bundle of the bus driver.
//  Revision : 1.0 - initial release
// ============================================================================
interface ram_bus_driver_if #(
    parameter int BURST_W = 4
);
    import ram_bus_driver_pkg::*;

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [c_RAM_ADDR_W-1:0] req_addr;
    logic [BURST_W-1:0]      req_len;
    logic [c_RAM_DATA_W-1:0] wr_data;
    logic [1:0]              wr_ublb;
    logic                    wr_ready;
    logic [c_RAM_DATA_W-1:0] rd_data;
    logic                    rd_valid;
    logic                    busy;
    logic                    ram_clk;
    logic [c_RAM_ADDR_W-1:0] ram_a;
    logic [c_RAM_DATA_W-1:0] ram_d_out;
    logic                    ram_d_oe;
    logic [c_RAM_DATA_W-1:0] ram_d_in;
    logic                    ram_ce1;
    logic                    ram_ce2;
    logic                    ram_adv;
    logic                    ram_oe;
    logic                    ram_we;
    logic                    ram_ub;
    logic                    ram_lb;

    modport slave (
        input  req_valid, req_write, req_addr, req_len, wr_data, wr_ublb, ram_d_in,
        output req_ready, wr_ready, rd_data, rd_valid, busy, ram_clk, ram_a,
               ram_d_out, ram_d_oe, ram_ce1, ram_ce2, ram_adv, ram_oe, ram_we,
               ram_ub, ram_lb
    );

    modport master (
        output req_valid, req_write, req_addr, req_len, wr_data, wr_ublb, ram_d_in,
        input  req_ready, wr_ready, rd_data, rd_valid, busy, ram_clk, ram_a,
               ram_d_out, ram_d_oe, ram_ce1, ram_ce2, ram_adv, ram_oe, ram_we,
               ram_ub, ram_lb
    );

endinterface
`default_nettype wire

// File: rtl/ram_bus_driver_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ram_bus_driver_clk_gen
//  Brief    : Divides mclk into the free-running ram_clk with rise/fall strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_bus_driver_clk_gen #(
    parameter int CLK_HALF = 4
) (
    input  wire  mclk,
    input  wire  reset_n,
    output logic ram_clk,
    output logic rise,
    output logic fall
);
    import ram_bus_driver_pkg::*;

    localparam int c_CNT_W = f_cnt_w(CLK_HALF);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_ram_clk;
    logic               w_term;

    assign w_term = (r_cnt == c_CNT_W'(CLK_HALF - 1));

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_ram_clk <= 1'b0;
        end else if (w_term) begin
            r_cnt     <= '0;
            r_ram_clk <= ~r_ram_clk;
        end else begin
            r_cnt     <= r_cnt + 1'b1;
        end
    end

    // Strobes mark the mclk whose closing edge toggles ram_clk, so logic
    // updated on a strobe changes in step with the ram_clk edge.
    assign ram_clk = r_ram_clk;
    assign rise    = w_term & ~r_ram_clk;
    assign fall    = w_term &  r_ram_clk;

endmodule
`default_nettype wire

// File: rtl/ram_bus_driver.sv
`default_nettype none
// ============================================================================
//  Module   : ram_bus_driver
//  Brief    : Turns single-request bursts into synchronous PSRAM bus waveforms.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_bus_driver #(
    parameter int CLK_HALF = 4,
    parameter int LATENCY  = 3,
    parameter int BURST_W  = 4
) (
    input wire               mclk,
    input wire               reset_n,
    ram_bus_driver_if.slave  bus
);
    import ram_bus_driver_pkg::*;

    localparam int c_LAT_W   = f_cnt_w(LATENCY);
    localparam bit c_NO_WAIT = (LATENCY == 1);

    logic                    w_rise;
    logic                    w_fall;
    logic                    w_ram_clk;
    logic                    w_enter_data;
    logic                    w_next_word;
    logic                    w_wr_take;

    logic [c_STATE_W-1:0]    r_state;
    logic                    r_write;
    logic [c_RAM_ADDR_W-1:0] r_addr;
    logic [BURST_W-1:0]      r_len;
    logic [BURST_W-1:0]      r_word_cnt;
    logic [c_LAT_W-1:0]      r_lat_cnt;
    logic                    r_req_ready;
    logic                    r_busy;
    logic                    r_ce1;
    logic                    r_adv;
    logic                    r_oe;
    logic                    r_we;
    logic                    r_ub;
    logic                    r_lb;
    logic [c_RAM_ADDR_W-1:0] r_a;
    logic [c_RAM_DATA_W-1:0] r_d_out;
    logic                    r_d_oe;
    logic [c_RAM_DATA_W-1:0] r_rd_data;
    logic                    r_rd_valid;

    ram_bus_driver_clk_gen #(
        .CLK_HALF (CLK_HALF)
    ) u_clk_gen (
        .mclk    (mclk),
        .reset_n (reset_n),
        .ram_clk (w_ram_clk),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    assign w_enter_data = w_fall & (((r_state == c_S_ADDR) & c_NO_WAIT) |
                                    ((r_state == c_S_WAIT) & (r_lat_cnt == '0)));
    assign w_next_word  = w_fall & (r_state == c_S_DATA) & (r_word_cnt != '0);
    assign w_wr_take    = r_write & (w_enter_data | w_next_word);

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_S_IDLE;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_lat_cnt   <= '0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_ce1       <= 1'b1;
            r_adv       <= 1'b1;
            r_oe        <= 1'b1;
            r_we        <= 1'b1;
            r_ub        <= 1'b1;
            r_lb        <= 1'b1;
            r_a         <= '0;
            r_d_out     <= '0;
            r_d_oe      <= 1'b0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;

            // A cleared req_ready while still in IDLE means a latched request
            // is waiting for the next ram_clk fall.
            if (r_req_ready && bus.req_valid) begin
                r_req_ready <= 1'b0;
                r_write     <= bus.req_write;
                r_addr      <= bus.req_addr;
                r_len       <= bus.req_len;
            end

            if (w_rise && (r_state == c_S_DATA) && !r_write) begin
                r_rd_data  <= bus.ram_d_in;
                r_rd_valid <= 1'b1;
            end

            if (w_fall) begin
                case (r_state)
                    c_S_IDLE: begin
                        if (!r_req_ready) begin
                            r_state <= c_S_ADDR;
                            r_busy  <= 1'b1;
                            r_ce1   <= 1'b0;
                            r_adv   <= 1'b0;
                            r_a     <= r_addr;
                            r_we    <= ~r_write;
                            r_oe    <= 1'b1;
                        end
                    end
                    c_S_ADDR: begin
                        r_adv <= 1'b1;
                        if (!c_NO_WAIT) begin
                            r_state   <= c_S_WAIT;
                            r_lat_cnt <= c_LAT_W'(LATENCY - 2);
                            if (!r_write) begin
                                r_oe <= 1'b0;
                                r_ub <= 1'b0;
                                r_lb <= 1'b0;
                            end
                        end
                    end
                    c_S_WAIT: begin
                        if (r_lat_cnt != '0) begin
                            r_lat_cnt <= r_lat_cnt - 1'b1;
                        end
                    end
                    c_S_DATA: begin
                        if (r_word_cnt == '0) begin
                            r_state <= c_S_RECOV;
                            r_ce1   <= 1'b1;
                            r_adv   <= 1'b1;
                            r_oe    <= 1'b1;
                            r_we    <= 1'b1;
                            r_ub    <= 1'b1;
                            r_lb    <= 1'b1;
                            r_a     <= '0;
                            r_d_out <= '0;
                            r_d_oe  <= 1'b0;
                        end else begin
                            r_word_cnt <= r_word_cnt - 1'b1;
                        end
                    end
                    c_S_RECOV: begin
                        r_state     <= c_S_IDLE;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                    default: begin
                        r_state <= c_S_IDLE;
                    end
                endcase
            end

            if (w_enter_data) begin
                r_state    <= c_S_DATA;
                r_word_cnt <= r_len;
                if (!r_write) begin
                    r_oe <= 1'b0;
                    r_ub <= 1'b0;
                    r_lb <= 1'b0;
                end
            end

            // A zero byte-enable still drives the data; only UB/LB mask it.
            if (w_wr_take) begin
                r_d_out <= bus.wr_data;
                r_d_oe  <= 1'b1;
                r_ub    <= ~bus.wr_ublb[1];
                r_lb    <= ~bus.wr_ublb[0];
            end
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.wr_ready  = w_wr_take;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.busy      = r_busy;
    assign bus.ram_clk   = w_ram_clk;
    assign bus.ram_a     = r_a;
    assign bus.ram_d_out = r_d_out;
    assign bus.ram_d_oe  = r_d_oe;
    assign bus.ram_ce1   = r_ce1;
    assign bus.ram_ce2   = 1'b1;
    assign bus.ram_adv   = r_adv;
    assign bus.ram_oe    = r_oe;
    assign bus.ram_we    = r_we;
    assign bus.ram_ub    = r_ub;
    assign bus.ram_lb    = r_lb;

endmodule
`default_nettype wire

// File: tb/tb_ram_bus_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_bus_driver
//  Brief    : Self-checking bench: PSRAM-side emulator plus burst-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_bus_driver;

    localparam int LAT  = 3;
    localparam int HALF = 4;
    localparam int PER  = 2 * HALF;

    logic mclk;
    logic reset_n;

    ram_bus_driver_if #(.BURST_W(4)) bus ();
    ram_bus_driver_if #(.BURST_W(4)) bus1 ();

    ram_bus_driver #(.CLK_HALF(HALF), .LATENCY(LAT), .BURST_W(4)) u_dut (
        .mclk    (mclk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    ram_bus_driver #(.CLK_HALF(HALF), .LATENCY(1), .BURST_W(4)) u_dut_lat1 (
        .mclk    (mclk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int n_cmp = 0;
    int n_bad = 0;

    // PSRAM-side emulator: samples the bus mid-period (just after each ram_clk rise)
    logic        em_prev_clk = 1'b0;
    int          em_period   = -1;
    logic        em_write    = 1'b0;
    logic [22:0] em_addr     = '0;
    int          em_bad      = 0;
    int          em_adv_cnt  = 0;
    int          cap_wr      = 0;
    logic [22:0] cap_a [512];
    logic [15:0] cap_d [512];
    logic [1:0]  cap_m [512];
    logic [15:0] rd_pat_base = 16'h0000;

    always @(negedge mclk) begin
        if (bus.ram_clk && !em_prev_clk) begin
            if (!bus.ram_ce1) begin
                if (!bus.ram_adv) begin
                    em_period  = 0;
                    em_adv_cnt = em_adv_cnt + 1;
                    em_write   = !bus.ram_we;
                    em_addr    = bus.ram_a;
                end else begin
                    em_period = em_period + 1;
                end
                if (bus.ram_a !== em_addr || bus.ram_ce2 !== 1'b1) em_bad = em_bad + 1;
                if (em_write && bus.ram_oe !== 1'b1) em_bad = em_bad + 1;
                if (em_write && em_period >= LAT) begin
                    if (bus.ram_d_oe !== 1'b1) em_bad = em_bad + 1;
                    if (cap_wr < 512) begin
                        cap_a[cap_wr] = bus.ram_a;
                        cap_d[cap_wr] = bus.ram_d_out;
                        cap_m[cap_wr] = ~{bus.ram_ub, bus.ram_lb};
                        cap_wr = cap_wr + 1;
                    end
                end
                if (!em_write && em_period >= 1 &&
                    (bus.ram_oe !== 1'b0 || bus.ram_ub !== 1'b0 || bus.ram_lb !== 1'b0))
                    em_bad = em_bad + 1;
                if (!em_write) bus.ram_d_in = rd_pat_base + 16'(em_period + 1 - LAT);
            end else begin
                em_period = -1;
            end
        end
        em_prev_clk = bus.ram_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [15:0] wdata [16];
    logic [1:0]  wublb [16];

    // One burst through the main DUT; expectations come from the burst rules:
    // len+1 words, word k at period LAT+k after ADDR, busy for LAT+len+2 periods.
    task automatic run_burst(input bit wr, input logic [22:0] addr, input int len,
                             input logic [15:0] rbase);
        int t, t0, nbusy, nwr, nrd, last_wr, last_rd, widx, cap0, bad0, adv0;
        bit seen, pend;
        t = 0; t0 = 0; nbusy = 0; nwr = 0; nrd = 0; last_wr = 0; last_rd = 0;
        widx = 0; seen = 0; pend = 0;
        cap0 = cap_wr; bad0 = em_bad; adv0 = em_adv_cnt;
        rd_pat_base   = rbase;
        bus.wr_data   = wdata[0];
        bus.wr_ublb   = wublb[0];
        while (!bus.req_ready && t < 100) begin
            @(negedge mclk);
            t++;
        end
        chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_len   = 4'(len);
        @(negedge mclk);
        bus.req_valid = 1'b0;
        bus.req_write = ~wr;
        bus.req_addr  = ~addr;
        bus.req_len   = ~4'(len);
        chk("req_ready_drop", 32'(bus.req_ready), 32'd0);
        t = 0;
        while (t < 1000) begin
            if (pend) begin
                if (widx < 15) widx++;
                bus.wr_data = wdata[widx];
                bus.wr_ublb = wublb[widx];
                pend = 0;
            end
            if (bus.busy) begin
                if (!seen) t0 = t;
                seen = 1;
                nbusy++;
            end
            if (bus.wr_ready) begin
                if (nwr == 0) chk("wr_first_ofs", 32'(t - t0), 32'(PER * LAT - 1));
                else          chk("wr_spacing", 32'(t - last_wr), 32'(PER));
                last_wr = t;
                nwr++;
                pend = 1;
            end
            if (bus.rd_valid) begin
                chk("rd_data", 32'(bus.rd_data), 32'(16'(rbase + 16'(nrd))));
                if (nrd == 0) chk("rd_first_ofs", 32'(t - t0), 32'(PER * LAT + HALF));
                else          chk("rd_spacing", 32'(t - last_rd), 32'(PER));
                last_rd = t;
                nrd++;
            end
            if (seen && !bus.busy) break;
            @(negedge mclk);
            t++;
        end
        chk("burst_done", 32'(seen && !bus.busy), 32'd1);
        chk("busy_cycles", 32'(nbusy), 32'(PER * (LAT + len + 2)));
        chk("req_ready_back", 32'(bus.req_ready), 32'd1);
        chk("wr_ready_cnt", 32'(nwr), wr ? 32'(len + 1) : 32'd0);
        chk("rd_valid_cnt", 32'(nrd), wr ? 32'd0 : 32'(len + 1));
        chk("bus_addr", 32'(em_addr), 32'(addr));
        chk("adv_periods", 32'(em_adv_cnt - adv0), 32'd1);
        chk("bus_protocol", 32'(em_bad - bad0), 32'd0);
        if (wr) begin
            chk("cap_words", 32'(cap_wr - cap0), 32'(len + 1));
            for (int k = 0; k <= len && cap0 + k < cap_wr; k++) begin
                chk("cap_addr", 32'(cap_a[cap0 + k]), 32'(addr));
                chk("cap_data", 32'(cap_d[cap0 + k]), 32'(wdata[k]));
                chk("cap_ublb", 32'(cap_m[cap0 + k]), 32'(wublb[k]));
            end
        end
    endtask

    int   rise_t [2];
    int   n_rise, n_strobe, n_ctl, n1_wr, t1_0, t1_first, t_wait, n_rdv;
    bit   ce_seen, seen1;
    logic prev_clk;

    initial begin
        reset_n        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_len    = '0;
        bus.wr_data    = '0;
        bus.wr_ublb    = '0;
        bus1.req_valid = 1'b0;
        bus1.req_write = 1'b0;
        bus1.req_addr  = '0;
        bus1.req_len   = '0;
        bus1.wr_data   = '0;
        bus1.wr_ublb   = 2'b11;
        bus1.ram_d_in  = '0;
        repeat (3) @(negedge mclk);

        chk("rst_ram_clk", 32'(bus.ram_clk), 32'd0);
        chk("rst_ctl", 32'({bus.ram_ce1, bus.ram_ce2, bus.ram_adv, bus.ram_oe,
                             bus.ram_we, bus.ram_ub, bus.ram_lb}), 32'h7f);
        chk("rst_ram_a", 32'(bus.ram_a), 32'd0);
        chk("rst_d", 32'({bus.ram_d_oe, bus.ram_d_out}), 32'd0);
        chk("rst_rd", 32'({bus.rd_valid, bus.rd_data}), 32'd0);
        chk("rst_flags", 32'({bus.wr_ready, bus.busy, bus.req_ready}), 32'b001);

        // Idle: free-running ram_clk, nothing else moving
        reset_n  = 1'b1;
        n_rise   = 0; n_strobe = 0; n_ctl = 0;
        prev_clk = bus.ram_clk;
        for (int t = 0; t < 40; t++) begin
            @(negedge mclk);
            if (bus.ram_clk && !prev_clk && n_rise < 2) begin
                rise_t[n_rise] = t;
                n_rise++;
            end
            prev_clk = bus.ram_clk;
            if (bus.wr_ready || bus.rd_valid) n_strobe++;
            if (!bus.ram_ce1 || !bus.req_ready || bus.busy) n_ctl++;
        end
        chk("idle_rises", 32'(n_rise), 32'd2);
        chk("idle_period", 32'(rise_t[1] - rise_t[0]), 32'(PER));
        chk("idle_strobes", 32'(n_strobe), 32'd0);
        chk("idle_ctl", 32'(n_ctl), 32'd0);

        // Single-word write
        wdata[0] = 16'hBEEF; wublb[0] = 2'b11;
        run_burst(1'b1, 23'h12345, 0, 16'h0000);

        // Four-word read, memory returns 0x1000+k
        run_burst(1'b0, 23'h00abc, 3, 16'h1000);

        // Byte-masked middle word
        wdata[0] = 16'h1111; wublb[0] = 2'b11;
        wdata[1] = 16'h2222; wublb[1] = 2'b01;
        wdata[2] = 16'h3333; wublb[2] = 2'b11;
        run_burst(1'b1, 23'h7fffff, 2, 16'h0000);

        // Randomised bursts
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 16; k++) begin
                wdata[k] = 16'($urandom);
                wublb[k] = 2'($urandom_range(0, 3));
            end
            run_burst(1'($urandom_range(0, 1)), 23'($urandom), $urandom_range(0, 7),
                      16'($urandom));
        end

        // LATENCY=1 instance: maximum-length write
        bus1.wr_data = 16'hA5A5;
        t_wait = 0;
        while (!bus1.req_ready && t_wait < 100) begin
            @(negedge mclk);
            t_wait++;
        end
        bus1.req_valid = 1'b1;
        bus1.req_write = 1'b1;
        bus1.req_addr  = 23'h000100;
        bus1.req_len   = 4'hf;
        @(negedge mclk);
        bus1.req_valid = 1'b0;
        n1_wr = 0; t1_0 = 0; t1_first = -1; ce_seen = 0; seen1 = 0;
        for (int t = 0; t < 400; t++) begin
            if (!bus1.ram_ce1 && !ce_seen) begin
                ce_seen = 1;
                t1_0    = t;
            end
            if (bus1.wr_ready) begin
                if (n1_wr == 0) t1_first = t - t1_0;
                n1_wr++;
            end
            if (bus1.busy) seen1 = 1;
            if (seen1 && !bus1.busy) break;
            @(negedge mclk);
        end
        chk("lat1_done", 32'(seen1 && !bus1.busy), 32'd1);
        chk("lat1_wr_cnt", 32'(n1_wr), 32'd16);
        chk("lat1_first_ofs", 32'(t1_first), 32'(PER - 1));

        // Reset in the DATA phase of a read
        rd_pat_base   = 16'h5a00;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 23'h000777;
        bus.req_len   = 4'hf;
        @(negedge mclk);
        bus.req_valid = 1'b0;
        n_rdv = 0;
        for (int t = 0; t < 300 && n_rdv < 2; t++) begin
            @(negedge mclk);
            if (bus.rd_valid) n_rdv++;
        end
        chk("mid_rd_valid", 32'(n_rdv), 32'd2);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ctl", 32'({bus.ram_ce1, bus.ram_adv, bus.ram_oe, bus.ram_we,
                                 bus.ram_ub, bus.ram_lb}), 32'h3f);
        chk("mid_rst_clk", 32'(bus.ram_clk), 32'd0);
        chk("mid_rst_flags", 32'({bus.busy, bus.req_ready, bus.rd_valid, bus.ram_d_oe}),
            32'b0100);
        chk("mid_rst_a", 32'(bus.ram_a), 32'd0);
        repeat (2) @(negedge mclk);
        reset_n = 1'b1;
        run_burst(1'b0, 23'h0abcde, 1, 16'hc0de);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
